uart: RTL and testbench

8N1 serial transceiver with independent transmitter and receiver running from a single 50 MHz system clock. The transmitter serialises a byte on a one-cycle write strobe. The receiver oversamples the line, reassembles bytes and holds a sticky ready flag until software or fabric logic clears it. It sits between fabric logic and the board UART pins and can be looped back tx→rx for self-test.

---
 rtl/uart.sv | 216 +++++++++++++++++++++
 tb/tb_uart.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
// uart: 8N1 transmitter and 16x-oversampling receiver sharing one system clock.
// Build option UART_FRAME_CHECK_EN: discard frames whose stop bit samples low.
module uart #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       write_en,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rdy,
  input  logic       rdy_clr
);

  localparam int TX_DIV = CLK_FREQ / BAUD;
  localparam int RX_DIV = CLK_FREQ / (BAUD * 16);
  localparam int TX_CW  = $clog2(TX_DIV + 1);
  localparam int RX_CW  = $clog2(RX_DIV + 1);
  localparam logic [TX_CW-1:0] TX_LAST = TX_CW'(TX_DIV - 1);
  localparam logic [RX_CW-1:0] RX_LAST = RX_CW'(RX_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_t           tx_state;
  logic [TX_CW-1:0] tx_div;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_bit_end;

  assign tx_bit_end = (tx_div == TX_LAST);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: begin
          if (write_en) begin
            tx_shift <= din;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_bit_end) begin
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_state <= DATA;
          end
        end
        DATA: begin
          if (tx_bit_end) begin
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 3'd1;
            end
          end
        end
        STOP: begin
          if (tx_bit_end) begin
            tx_busy  <= 1'b0;
            tx_state <= IDLE;
          end
        end
        default: tx_state <= IDLE;
      endcase

      // Bit-period counter runs only while a frame is in flight, so it is
      // always zero when the next request is accepted.
      if (tx_state != IDLE) begin
        tx_div <= tx_bit_end ? '0 : tx_div + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic             rx_meta;
  logic             rx_sync;
  logic [RX_CW-1:0] rx_div;
  logic             rx_tick;
  state_t           rx_state;
  logic [3:0]       rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
`ifdef UART_FRAME_CHECK_EN
  logic             rx_ferr;
`endif

  // Synchronizer resets to the idle level so reset release is not a start bit.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign rx_tick = (rx_div == RX_LAST);

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      rx_div <= '0;
    end else begin
      rx_div <= rx_tick ? '0 : rx_div + 1'b1;
    end
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      dout     <= '0;
      rdy      <= 1'b0;
`ifdef UART_FRAME_CHECK_EN
      rx_ferr  <= 1'b0;
`endif
    end else begin
      // A completion later in this block overrides the clear: set wins.
      if (rdy_clr) rdy <= 1'b0;

      if (rx_tick) begin
        case (rx_state)
          IDLE: begin
            if (!rx_sync) begin
              rx_cnt   <= '0;
              rx_state <= START;
            end
          end
          START: begin
            if (rx_cnt == 4'd7) begin
              rx_cnt   <= '0;
              rx_bit   <= '0;
              rx_state <= rx_sync ? IDLE : DATA;
            end else begin
              rx_cnt <= rx_cnt + 4'd1;
            end
          end
          DATA: begin
            if (rx_cnt == 4'd15) begin
              rx_cnt   <= '0;
              rx_shift <= {rx_sync, rx_shift[7:1]};
              if (rx_bit == 3'd7) rx_state <= STOP;
              else                rx_bit   <= rx_bit + 3'd1;
            end else begin
              rx_cnt <= rx_cnt + 4'd1;
            end
          end
          STOP: begin
`ifdef UART_FRAME_CHECK_EN
            if (rx_ferr) begin
              if (rx_sync) begin
                rx_ferr  <= 1'b0;
                rx_state <= IDLE;
              end
            end else if (rx_cnt == 4'd15) begin
              rx_cnt <= '0;
              if (rx_sync) begin
                dout     <= rx_shift;
                rdy      <= 1'b1;
                rx_state <= IDLE;
              end else begin
                rx_ferr <= 1'b1;
              end
            end else begin
              rx_cnt <= rx_cnt + 4'd1;
            end
`else
            if (rx_cnt == 4'd15) begin
              rx_cnt   <= '0;
              dout     <= rx_shift;
              rdy      <= 1'b1;
              rx_state <= IDLE;
            end else begin
              rx_cnt <= rx_cnt + 4'd1;
            end
`endif
          end
          default: rx_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart.sv
// tb_uart: directed and randomized checks of the uart against a frame-level model.
// A second, fast-baud instance carries the full 256-byte loopback sweep.
module tb_uart;

  localparam int BIT   = 434;
  localparam int FRAME = 10 * BIT;

  logic       clk50 = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       write_en;
  logic       tx;
  logic       tx_busy;
  logic       rx;
  logic [7:0] dout;
  logic       rdy;
  logic       rdy_clr;
  logic       loop_en;
  logic       rx_drv;

  logic [7:0] f_din;
  logic       f_we;
  logic       f_tx;
  logic       f_busy;
  logic [7:0] f_dout;
  logic       f_rdy;
  logic       f_clr;

  int n_total = 0;
  int n_pass  = 0;

  always #10 clk50 = ~clk50;

  assign rx = loop_en ? tx : rx_drv;

  uart dut (
    .clk50   (clk50),
    .rst_n   (rst_n),
    .din     (din),
    .write_en(write_en),
    .tx      (tx),
    .tx_busy (tx_busy),
    .rx      (rx),
    .dout    (dout),
    .rdy     (rdy),
    .rdy_clr (rdy_clr)
  );

  // 16 clocks per bit, one oversample tick per clock.
  uart #(.CLK_FREQ(50_000_000), .BAUD(3_125_000)) dut_fast (
    .clk50   (clk50),
    .rst_n   (rst_n),
    .din     (f_din),
    .write_en(f_we),
    .tx      (f_tx),
    .tx_busy (f_busy),
    .rx      (f_tx),
    .dout    (f_dout),
    .rdy     (f_rdy),
    .rdy_clr (f_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Line level of bit slot i (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[3'(i - 1)];
  endfunction

  // Transmit b and watch tx/tx_busy every cycle; optionally issue a second
  // write of poke_val at cycle poke_at of the frame.
  task automatic run_frame(input logic [7:0] b, input int poke_at, input logic [7:0] poke_val,
                           output int mism, output int busy_len);
    @(negedge clk50);
    din      = b;
    write_en = 1'b1;
    mism     = 0;
    busy_len = 0;
    for (int k = 0; k < FRAME + 5; k++) begin
      @(negedge clk50);
      write_en = (k == poke_at);
      if (k == poke_at) din = poke_val;
      if (tx_busy === 1'b1) busy_len++;
      if (tx !== (k < FRAME ? frame_bit(b, k / BIT) : 1'b1)) mism++;
    end
    write_en = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_val);
    for (int i = 0; i < 10; i++) begin
      rx_drv = (i == 9) ? stop_val : frame_bit(b, i);
      repeat (BIT) @(negedge clk50);
    end
    rx_drv = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk50);
    rdy_clr = 1'b1;
    @(negedge clk50);
    rdy_clr = 1'b0;
  endtask

  initial begin
    int         mism;
    int         blen;
    int         sweep_bad;
    logic       got;
    logic       seen;
    logic [7:0] seen_d;
    logic [7:0] b1, b2, b3, b4;

    rst_n    = 1'b0;
    din      = '0;
    write_en = 1'b0;
    rdy_clr  = 1'b0;
    loop_en  = 1'b0;
    rx_drv   = 1'b1;
    f_din    = '0;
    f_we     = 1'b0;
    f_clr    = 1'b0;

    repeat (3) @(negedge clk50);
    check("reset_tx",      32'(tx),      1);
    check("reset_tx_busy", 32'(tx_busy), 0);
    check("reset_rdy",     32'(rdy),     0);
    check("reset_dout",    32'(dout),    0);
    check("reset_fast_tx", 32'(f_tx),    1);
    rst_n = 1'b1;
    @(negedge clk50);

    // Full loopback sweep on the fast instance.
    sweep_bad = 0;
    for (int b = 0; b < 256; b++) begin
      @(negedge clk50);
      f_din = 8'(b);
      f_we  = 1'b1;
      @(negedge clk50);
      f_we = 1'b0;
      got  = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
        if (f_rdy === 1'b1) got = 1'b1;
        else @(negedge clk50);
      end
      if (!got || f_dout !== 8'(b)) sweep_bad++;
      f_clr = 1'b1;
      @(negedge clk50);
      f_clr = 1'b0;
      if (f_rdy !== 1'b0) sweep_bad++;
      for (int k = 0; k < 400 && f_busy !== 1'b0; k++) @(negedge clk50);
      if (f_busy !== 1'b0) sweep_bad++;
    end
    check("loopback_sweep_bad", 32'(sweep_bad), 0);

    // Bit timing of 8'hA5, looped back into the receiver.
    loop_en = 1'b1;
    run_frame(8'hA5, -1, 8'h00, mism, blen);
    check("a5_bit_mismatch", 32'(mism), 0);
    check("a5_busy_len",     32'(blen), 32'(FRAME));
    check("a5_loop_rdy",     32'(rdy),  1);
    check("a5_loop_dout",    32'(dout), 32'hA5);
    pulse_clr();
    check("a5_rdy_clr", 32'(rdy), 0);

    // Second write mid-frame is ignored.
    run_frame(8'h3C, 1000 + int'($urandom_range(0, 2000)), 8'hFF, mism, blen);
    check("busy_ign_mismatch", 32'(mism), 0);
    check("busy_ign_len",      32'(blen), 32'(FRAME));
    check("busy_ign_dout",     32'(dout), 32'h3C);
    pulse_clr();

    // Sticky rdy and overwrite, bytes driven directly on rx.
    loop_en = 1'b0;
    b1 = 8'($urandom_range(1, 255));
    if (b1 == 8'h11) b1 = 8'h5A;
    rx_frame(b1, 1'b1);
    check("rx1_rdy",  32'(rdy),  1);
    check("rx1_dout", 32'(dout), 32'(b1));
    repeat (200) @(negedge clk50);
    check("rdy_sticky", 32'(rdy), 1);
    rx_frame(8'h11, 1'b1);
    check("overwrite_rdy",  32'(rdy),  1);
    check("overwrite_dout", 32'(dout), 32'h11);
    pulse_clr();
    check("overwrite_clr", 32'(rdy), 0);

    // rdy_clr held across completion: the set must still be visible.
    b2 = 8'($urandom_range(0, 255));
    if (b2 == 8'h11) b2 = 8'hC3;
    rdy_clr = 1'b1;
    seen    = 1'b0;
    seen_d  = '0;
    fork
      rx_frame(b2, 1'b1);
      begin
        for (int k = 0; k < FRAME && !seen; k++) begin
          @(negedge clk50);
          if (rdy === 1'b1) begin
            seen    = 1'b1;
            seen_d  = dout;
            rdy_clr = 1'b0;
          end
        end
      end
    join
    rdy_clr = 1'b0;
    check("coincident_seen", 32'(seen),   1);
    check("coincident_dout", 32'(seen_d), 32'(b2));
    @(negedge clk50);
    check("coincident_rdy_hold", 32'(rdy), 1);
    pulse_clr();

    // Short low glitch is a false start.
    repeat ($urandom_range(0, 40)) @(negedge clk50);
    rx_drv = 1'b0;
    repeat (100) @(negedge clk50);
    rx_drv = 1'b1;
    repeat (2 * BIT) @(negedge clk50);
    check("glitch_no_rdy", 32'(rdy),  0);
    check("glitch_dout",   32'(dout), 32'(b2));

    // Frame with a low stop bit.
    b3 = b2 ^ 8'(1 + $urandom_range(0, 254));
    rx_frame(b3, 1'b0);
    repeat (BIT) @(negedge clk50);
`ifdef UART_FRAME_CHECK_EN
    check("ferr_no_rdy", 32'(rdy),  0);
    check("ferr_dout",   32'(dout), 32'(b2));
`else
    check("ferr_rdy",  32'(rdy),  1);
    check("ferr_dout", 32'(dout), 32'(b3));
`endif
    pulse_clr();

    // Reset while the transmitter is still in flight.
    loop_en = 1'b1;
    b4 = 8'($urandom_range(1, 255));
    @(negedge clk50);
    din      = b4;
    write_en = 1'b1;
    @(negedge clk50);
    write_en = 1'b0;
    for (int k = 0; k < FRAME && rdy !== 1'b1; k++) @(negedge clk50);
    check("pre_reset_rdy",  32'(rdy),     1);
    check("pre_reset_busy", 32'(tx_busy), 1);
    rst_n = 1'b0;
    @(negedge clk50);
    check("midreset_tx",      32'(tx),      1);
    check("midreset_tx_busy", 32'(tx_busy), 0);
    check("midreset_rdy",     32'(rdy),     0);
    check("midreset_dout",    32'(dout),    0);
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk50);
    check("post_reset_no_rdy",  32'(rdy),     0);
    check("post_reset_tx_idle", 32'(tx),      1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
